// File: rtl/counter_access_ctrl_pkg.sv
// counter_access_pkg: op and FSM state encodings shared by the counter access controller.
package counter_access_pkg;
    typedef enum logic [1:0] {
        OP_DOWN = 2'b00,
        OP_UP   = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_ARB,
        ST_EXEC,
        ST_RESP
    } state_e;
endpackage

// File: rtl/counter_access_ctrl_if.sv
// counter_access_ctrl_if: requester, response and counter-pin bundle of the counter access controller.
interface counter_access_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_count;
    logic                  rsp_sat;
    logic                  cnt_en;
    logic                  cnt_up;
    logic                  cnt_load;
    logic [WIDTH-1:0]      cnt_d;
    logic [WIDTH-1:0]      cnt_q;
    modport slave (
        input  req_valid, req_op, req_data, rsp_ready, cnt_q,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat, cnt_en, cnt_up, cnt_load, cnt_d
    );
    modport master (
        output req_valid, req_op, req_data, rsp_ready, cnt_q,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat, cnt_en, cnt_up, cnt_load, cnt_d
    );
endinterface

// File: rtl/counter_access_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, lowest index at or after ptr_i wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);
    logic [N-1:0] rot, pri;
    // Rotate so ptr_i sits at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({req_i, req_i} >> ptr_i);
        pri   = rot & (-rot);
        gnt_o = N'(({pri, pri} << ptr_i) >> N);
    end
endmodule

// File: rtl/counter_access_ctrl.sv
// counter_access_ctrl: round-robin access controller sequencing commands onto one shared counter.
module counter_access_ctrl
    import counter_access_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_access_ctrl_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [WIDTH-1:0] MAX = '1;
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, gid;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sat_q, sat_d, sat, exec, accept;
    logic [NREQ-1:0]  gnt;
    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );
    always_comb begin
        gid = '0;
        for (int i = 0; i < NREQ; i++) gid = gnt[i] ? IW'(i) : gid;
    end
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        data_d        = data_q;
        sat_d         = sat_q;
        exec          = state_q == ST_EXEC;
        // Gated by reset so nothing is granted while reset is held.
        bus.req_ready = (state_q == ST_ARB && !reset) ? gnt : '0;
        accept        = |(bus.req_valid & bus.req_ready);
        sat           = !WRAP && ((op_q == OP_UP && bus.cnt_q == MAX) || (op_q == OP_DOWN && bus.cnt_q == '0));
        bus.cnt_en    = exec && op_q != OP_READ && !sat;
        bus.cnt_up    = exec && op_q == OP_UP;
        bus.cnt_load  = exec && op_q == OP_LOAD;
        bus.cnt_d     = (exec && op_q == OP_LOAD) ? data_q : '0;
        bus.rsp_valid = state_q == ST_RESP;
        bus.rsp_id    = (state_q == ST_RESP) ? id_q : '0;
        bus.rsp_count = (state_q == ST_RESP) ? bus.cnt_q : '0;
        bus.rsp_sat   = state_q == ST_RESP && sat_q;
        if (accept) begin
            state_d = ST_EXEC;
            id_d    = gid;
            op_d    = op_e'(bus.req_op[2*int'(gid) +: 2]);
            data_d  = bus.req_data[WIDTH*int'(gid) +: WIDTH];
        end
        if (exec) begin
            state_d = ST_RESP;
            sat_d   = sat;
        end
        if (state_q == ST_RESP && bus.rsp_ready) begin
            state_d = ST_ARB;
            ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + IW'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            op_q    <= OP_DOWN;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_counter_access_ctrl.sv
// tb_counter_access_ctrl: wrapping and saturating controllers on real counters, checked against a transaction model.
module tb_counter_access_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rv = '0;
    logic [7:0] ro = '0;
    logic [15:0] rd = '0;
    logic       rr = 1'b1;
    logic [3:0] qw = 4'd0, qs = 4'd0;
    int total = 0, bad = 0;
    int age = 0, ptr_m = 0, id_m = 0, op_m = 0, d_m = 0, cw = 0, cs = 0, sat_m = 0;
    int p, er;
    bit ex, rs, sb;
    counter_access_ctrl_if #(.NREQ(4), .WIDTH(4)) bw ();
    counter_access_ctrl_if #(.NREQ(4), .WIDTH(4)) bs ();
    assign bw.req_valid = rv;
    assign bw.req_op    = ro;
    assign bw.req_data  = rd;
    assign bw.rsp_ready = rr;
    assign bw.cnt_q     = qw;
    assign bs.req_valid = rv;
    assign bs.req_op    = ro;
    assign bs.req_data  = rd;
    assign bs.rsp_ready = rr;
    assign bs.cnt_q     = qs;
    counter_access_ctrl #(.NREQ(4), .WIDTH(4), .WRAP(1'b1)) u_w (.clk(clk), .reset(reset), .bus(bw.slave));
    counter_access_ctrl #(.NREQ(4), .WIDTH(4), .WRAP(1'b0)) u_s (.clk(clk), .reset(reset), .bus(bs.slave));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        qw <= bw.cnt_load ? bw.cnt_d : bw.cnt_en ? (bw.cnt_up ? qw + 4'd1 : qw - 4'd1) : qw;
        qs <= bs.cnt_load ? bs.cnt_d : bs.cnt_en ? (bs.cnt_up ? qs + 4'd1 : qs - 4'd1) : qs;
    end
    task automatic chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
        end
    endtask
    function automatic int pick(logic [3:0] v, int ptr);
        for (int k = 0; k < 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction
    // Transaction-level reference: arbitrate when idle, one execute cycle, respond until taken.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready_w", bw.req_ready, 0);
            chk("rst_ready_s", bs.req_ready, 0);
            chk("rst_en_w", bw.cnt_en, 0);
            chk("rst_en_s", bs.cnt_en, 0);
            chk("rst_rsp_w", bw.rsp_valid, 0);
            chk("rst_rsp_s", bs.rsp_valid, 0);
            age = 0;
            ptr_m = 0;
        end else begin
            p  = (age == 0) ? pick(rv, ptr_m) : -1;
            er = (p < 0) ? 0 : (1 << p);
            ex = age == 1;
            rs = age >= 2;
            sb = (op_m == 1 && cs == 15) || (op_m == 0 && cs == 0);
            chk("ready_w", bw.req_ready, er);
            chk("ready_s", bs.req_ready, er);
            chk("en_w", bw.cnt_en, int'(ex && op_m != 3));
            chk("en_s", bs.cnt_en, int'(ex && op_m != 3 && !sb));
            chk("load_w", bw.cnt_load, int'(ex && op_m == 2));
            chk("load_s", bs.cnt_load, int'(ex && op_m == 2));
            chk("d_w", bw.cnt_d, (ex && op_m == 2) ? d_m : 0);
            chk("d_s", bs.cnt_d, (ex && op_m == 2) ? d_m : 0);
            if (!ex || op_m != 3) begin
                chk("up_w", bw.cnt_up, int'(ex && op_m == 1));
                chk("up_s", bs.cnt_up, int'(ex && op_m == 1));
            end
            chk("rsp_valid_w", bw.rsp_valid, int'(rs));
            chk("rsp_valid_s", bs.rsp_valid, int'(rs));
            if (rs) begin
                chk("rsp_id_w", bw.rsp_id, id_m);
                chk("rsp_id_s", bs.rsp_id, id_m);
                chk("rsp_count_w", bw.rsp_count, cw);
                chk("rsp_count_s", bs.rsp_count, cs);
                chk("rsp_sat_w", bw.rsp_sat, 0);
                chk("rsp_sat_s", bs.rsp_sat, sat_m);
            end
            if (p >= 0) begin
                id_m = p;
                op_m = int'(ro[2*p +: 2]);
                d_m  = int'(rd[4*p +: 4]);
                age  = 1;
            end else if (ex) begin
                sat_m = int'(sb);
                cw = (op_m == 2) ? d_m : (op_m == 1) ? (cw + 1) % 16 : (op_m == 0) ? (cw + 15) % 16 : cw;
                cs = (op_m == 2) ? d_m : (op_m == 1) ? (cs == 15 ? 15 : cs + 1) : (op_m == 0) ? (cs == 0 ? 0 : cs - 1) : cs;
                age = 2;
            end else if (rs && rr) begin
                ptr_m = (id_m + 1) % 4;
                age = 0;
            end
        end
    end
    task automatic wait_acc(int r);
        bit got = 0;
        int t = 0;
        while (!got && t < 50) begin
            @(negedge clk);
            got = rv[r] && bw.req_ready[r];
            t++;
            @(posedge clk); #1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        rv[r] = 1'b0;
    endtask
    task automatic op1(int r, logic [1:0] op, logic [3:0] d, output int c_w, output int c_s, output int s_s, output int lat);
        rv[r] = 1'b1;
        ro[2*r +: 2] = op;
        rd[4*r +: 4] = d;
        wait_acc(r);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bw.rsp_valid) break;
        end
        c_w = bw.rsp_count;
        c_s = bs.rsp_count;
        s_s = bs.rsp_sat;
        @(posedge clk); #1;
    endtask
    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    int a, b, s, lat;
    int gq[$], cq[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    initial begin
        idle(3);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", bw.req_ready, 0);
            chk("idle_en", bw.cnt_en, 0);
            chk("idle_rsp", bw.rsp_valid, 0);
        end
        @(posedge clk); #1;
        op1(0, 2'b10, 4'hA, a, b, s, lat);
        chk("load_a_count", a, 10);
        chk("load_a_lat", lat, 2);
        op1(0, 2'b01, 4'h0, a, b, s, lat);
        chk("up_b_count", a, 11);
        chk("up_b_lat", lat, 2);
        op1(0, 2'b10, 4'hF, a, b, s, lat);
        op1(0, 2'b01, 4'h0, a, b, s, lat);
        chk("wrap_up_count", a, 0);
        chk("sat_up_count", b, 15);
        chk("sat_up_flag", s, 1);
        op1(0, 2'b10, 4'h0, a, b, s, lat);
        op1(0, 2'b00, 4'h0, a, b, s, lat);
        chk("wrap_down_count", a, 15);
        chk("sat_down_count", b, 0);
        chk("sat_down_flag", s, 1);
        rr = 1'b0;
        op1(2, 2'b11, 4'h3, a, b, s, lat);
        rv[1] = 1'b1;
        ro[3:2] = 2'b01;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", bw.rsp_valid, 1);
            chk("hold_count_w", bw.rsp_count, 15);
            chk("hold_count_s", bs.rsp_count, 0);
            chk("hold_id", bw.rsp_id, 2);
            chk("hold_ready", bw.req_ready, 0);
            chk("hold_en", bw.cnt_en, 0);
            @(posedge clk); #1;
        end
        rr = 1'b1;
        idle(1);
        @(negedge clk);
        chk("release_gnt", bw.req_ready, 4'b0010);
        @(posedge clk); #1;
        rv[1] = 1'b0;
        idle(4);
        op1(2, 2'b11, 4'h0, a, b, s, lat);
        rv[3] = 1'b1;
        ro[7:6] = 2'b01;
        wait_acc(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rv = 4'b1100;
        ro = 8'b0101_0000;
        @(negedge clk);
        chk("post_rst_gnt", bw.req_ready, 4'b0100);
        chk("post_rst_gnt_s", bs.req_ready, 4'b0100);
        @(posedge clk); #1;
        rv = '0;
        idle(4);
        op1(0, 2'b10, 4'h5, a, b, s, lat);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rv = 4'b1111;
        ro = 8'b0101_0101;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (bw.req_ready[i]) gq.push_back(i);
            if (bw.rsp_valid) cq.push_back(int'(bw.rsp_count));
            @(posedge clk); #1;
        end
        rv = '0;
        chk("rr_grants", gq.size(), 5);
        chk("rr_resps", cq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (k < gq.size()) ? gq[k] : -1, exp_g[k]);
            chk("rr_count", (k < cq.size()) ? cq[k] : -1, 6 + k);
        end
        idle(4);
        for (int c = 0; c < 800; c++) begin
            logic [3:0] acc;
            @(negedge clk);
            acc = rv & bw.req_ready;
            @(posedge clk); #1;
            rv = rv & ~acc;
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && $urandom_range(3) == 0) begin
                    rv[i] = 1'b1;
                    ro[2*i +: 2] = 2'($urandom_range(3));
                    rd[4*i +: 4] = 4'($urandom_range(15));
                end
            end
            rr = $urandom_range(2) != 0;
        end
        rv = '0;
        rr = 1'b1;
        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
